// File: rtl/rom_sum_scheduler.sv
// rom_sum_scheduler
//   Two-requester round-robin job scheduler for the ROM-read/accumulate path.
//   Each job is (base, count). The granted job walks rom_addr from base for
//   count words, sums the returned rom_data modulo 2^DATA_W, and presents the
//   sum tagged with the requester id on a valid/ready result port.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid[1:0]          per-requester job valid
//   req_base[2*ADDR_W-1:0]  per-requester base address, slice i*ADDR_W
//   req_count[2*(ADDR_W+1)-1:0] per-requester word count (0..2^ADDR_W)
//   req_ready[1:0]          combinational accept strobe (IDLE, granted only)
//   rom_addr                registered ROM address
//   rom_data                ROM read data, valid ROM_LAT cycles after rom_addr
//   res_valid/res_ready     result handshake
//   res_sum, res_id         accumulated sum and requester id of the result
//   busy                    high whenever the controller is not idle
module rom_sum_scheduler #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  input  logic [2*ADDR_W-1:0]       req_base,
  input  logic [2*(ADDR_W+1)-1:0]   req_count,
  output logic [1:0]                req_ready,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_sum,
  output logic                      res_id,
  output logic                      busy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       DRAIN_LAST = 3'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_nxt;

  logic                rr_last;     // requester granted most recently
  logic                gnt_id;
  logic [ADDR_W-1:0]   base_sel;
  logic [CNT_W-1:0]    cnt_sel;
  logic                accept;
  logic                issue;
  logic                last_issue;

  logic [ADDR_W-1:0]   base_r;
  logic [CNT_W-1:0]    idx;
  logic [CNT_W-1:0]    idx_nxt;
  logic [CNT_W-1:0]    cnt_last;    // count-1, index of the final word
  logic [ROM_LAT-1:0]  vpipe;       // tracks issued addresses through the ROM
  logic [2:0]          drain_cnt;
  logic [DATA_W-1:0]   acc;

  assign res_sum = acc;
  assign idx_nxt = idx + CNT_ONE;

  // Round-robin grant: a lone requester always wins; on a tie the one not
  // granted last time wins.
  always_comb begin
    case (req_valid)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~rr_last;
      default: gnt_id = 1'b0;
    endcase
    base_sel = gnt_id ? req_base[ADDR_W +: ADDR_W] : req_base[0 +: ADDR_W];
    cnt_sel  = gnt_id ? req_count[CNT_W +: CNT_W]  : req_count[0 +: CNT_W];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and control outputs
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    issue      = 1'b0;
    last_issue = (idx == cnt_last);
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (req_valid[gnt_id]) begin
          req_ready[gnt_id] = 1'b1;
          state_nxt = (cnt_sel == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (last_issue) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    accept = req_ready[0] | req_ready[1];
  end

  // Datapath: address sequencing, latency tracking and accumulation.
  // rom_addr is loaded with base on acceptance so the first word is issued
  // in the first ISSUE cycle; the final ROM return lands on the same edge
  // that leaves DRAIN, so acc is already complete when DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      rr_last   <= 1'b1;
      base_r    <= '0;
      idx       <= '0;
      cnt_last  <= '0;
      vpipe     <= '0;
      drain_cnt <= '0;
      acc       <= '0;
    end else begin
      res_valid <= (state_nxt == DONE);

      vpipe[0] <= issue;
      for (int unsigned i = 1; i < unsigned'(ROM_LAT); i++) begin
        vpipe[i] <= vpipe[i-1];
      end

      if (vpipe[ROM_LAT-1]) begin
        acc <= acc + rom_data;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            base_r    <= base_sel;
            cnt_last  <= cnt_sel - CNT_ONE;
            res_id    <= gnt_id;
            rr_last   <= gnt_id;
            acc       <= '0;
            idx       <= '0;
            drain_cnt <= '0;
            if (cnt_sel != '0) begin
              rom_addr <= base_sel;
            end
          end
        end
        ISSUE: begin
          if (!last_issue) begin
            idx      <= idx_nxt;
            rom_addr <= base_r + idx_nxt[ADDR_W-1:0];
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_sum_scheduler.sv
// Self-checking bench for rom_sum_scheduler: a directed vector table, a
// mid-job reset sequence, and randomized jobs checked against a reference
// sum/arbitration model.
module tb_rom_sum_scheduler;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [2*AW-1:0] req_base = '0;
  logic [2*(AW+1)-1:0] req_count = '0;
  logic [1:0]      req_ready;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [DW-1:0]   res_sum;
  logic            res_id;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_sum_scheduler #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_base  (req_base),
    .req_count (req_count),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .busy      (busy)
  );

  // ROM model with LAT-cycle read latency
  logic [DW-1:0] rom   [256];
  logic [DW-1:0] rpipe [LAT];
  always @(posedge clk) begin
    rpipe[0] <= rom[rom_addr];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign rom_data = rpipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_rom(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0:       rom[i] = 32'(i);
        1:       rom[i] = 32'hFFFF_FFFF;
        default: rom[i] = $urandom;
      endcase
    end
  endtask

  // Reference: modular sum of count words starting at base, address wrapping
  function automatic logic [31:0] ref_sum(input int base, input int count);
    logic [31:0] s = '0;
    for (int i = 0; i < count; i++) s += rom[(base + i) % 256];
    return s;
  endfunction

  task automatic do_job(input string name, input logic [1:0] vld,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input logic [8:0] c0, input logic [8:0] c1,
                        input logic exp_id, input logic [31:0] exp_sum,
                        input int stall);
    int k;
    int bad;
    int cnt;
    int exp_lat;
    logic [7:0]  base;
    logic [7:0]  addr_before;
    logic [7:0]  addrs[$];
    logic [31:0] hold_sum;
    logic        hold_id;
    base = exp_id ? b1 : b0;
    cnt  = exp_id ? int'(c1) : int'(c0);
    @(negedge clk);
    req_base  = {b1, b0};
    req_count = {c1, c0};
    req_valid = vld;
    #1;
    k = 0;
    while (req_ready == 2'b00 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({name, ".ready"}, req_ready, 2'b01 << exp_id);
    if (req_ready == 2'b00) begin
      req_valid = '0;
      return;
    end
    addr_before = rom_addr;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    addrs.push_back(rom_addr);
    bad = 0;
    k = 0;
    while (!res_valid && k < 400) begin
      if (req_ready != 2'b00) bad++;
      @(negedge clk);
      k++;
      if (rom_addr != addrs[$]) addrs.push_back(rom_addr);
    end
    chk({name, ".ready_low"}, bad, 0);
    exp_lat = (cnt == 0) ? 1 : cnt + LAT + 1;
    chk({name, ".latency"}, k + 1, exp_lat);
    chk({name, ".sum"}, res_sum, exp_sum);
    chk({name, ".id"}, res_id, exp_id);
    bad = 0;
    if (cnt == 0) begin
      if (addrs.size() != 1 || addrs[0] != addr_before) bad++;
    end else begin
      if (addrs.size() != cnt) bad++;
      for (int i = 0; i < addrs.size(); i++)
        if (addrs[i] != 8'(int'(base) + i)) bad++;
    end
    chk({name, ".addr_seq"}, bad, 0);
    // hold off the consumer while new requests knock
    hold_sum = res_sum;
    hold_id  = res_id;
    bad = 0;
    req_valid = 2'b11;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!res_valid || res_sum !== hold_sum || res_id !== hold_id || req_ready != 2'b00) bad++;
    end
    req_valid = '0;
    if (stall > 0) chk({name, ".stall"}, bad, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({name, ".release"}, {res_valid, busy}, 2'b00);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  vld;
    logic [7:0]  b0, b1;
    logic [8:0]  c0, c1;
    logic        id;
    logic [31:0] sum;
    int          rom_mode;
    int          stall;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string name, input logic [1:0] vld,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [8:0] c0, input logic [8:0] c1,
                         input logic id, input logic [31:0] sum,
                         input int rom_mode, input int stall);
    vec_t v;
    v.name = name; v.vld = vld; v.b0 = b0; v.b1 = b1; v.c0 = c0; v.c1 = c1;
    v.id = id; v.sum = sum; v.rom_mode = rom_mode; v.stall = stall;
    vq.push_back(v);
  endtask

  initial begin
    logic       last_gnt;
    logic [1:0] vld;
    logic [7:0] b0, b1;
    logic [8:0] c0, c1;
    logic       g;

    //       name      vld    b0    b1    c0    c1   id   sum            rom stall
    add_vec("tie_a",  2'b11, 8'd10, 8'd20, 9'd3,   9'd2, 1'b0, 32'd33,        0, 10);
    add_vec("tie_b",  2'b11, 8'd10, 8'd20, 9'd3,   9'd2, 1'b1, 32'd41,        0, 2);
    add_vec("tie_c",  2'b11, 8'd10, 8'd20, 9'd3,   9'd2, 1'b0, 32'd33,        0, 0);
    add_vec("long",   2'b01, 8'd0,  8'd77, 9'd200, 9'd5, 1'b0, 32'd19900,     0, 0);
    add_vec("wrap",   2'b10, 8'd3,  8'd254,9'd9,   9'd4, 1'b1, 32'd510,       0, 1);
    add_vec("zero",   2'b01, 8'd40, 8'd0,  9'd0,   9'd0, 1'b0, 32'd0,         0, 0);
    add_vec("ones",   2'b01, 8'd0,  8'd0,  9'd256, 9'd0, 1'b0, 32'hFFFF_FF00, 1, 0);

    set_rom(0);
    repeat (2) @(negedge clk);
    chk("rst.rom_addr", rom_addr, 0);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.res_sum", res_sum, 0);
    chk("rst.res_id", res_id, 0);
    chk("rst.busy", busy, 0);
    chk("rst.req_ready", req_ready, 0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      set_rom(vq[i].rom_mode);
      do_job(vq[i].name, vq[i].vld, vq[i].b0, vq[i].b1, vq[i].c0, vq[i].c1,
             vq[i].id, vq[i].sum, vq[i].stall);
    end

    // Reset in the middle of an issuing job
    set_rom(0);
    @(negedge clk);
    req_base  = {8'd50, 8'd0};
    req_count = {9'd100, 9'd0};
    req_valid = 2'b10;
    #1;
    chk("abort.ready", req_ready, 2'b10);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    chk("abort.busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort.rom_addr", rom_addr, 0);
    chk("abort.res_valid", res_valid, 0);
    chk("abort.res_sum", res_sum, 0);
    chk("abort.res_id", res_id, 0);
    chk("abort.busy_low", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_job("post_rst", 2'b01, 8'd0, 8'd0, 9'd2, 9'd0, 1'b0, 32'd1, 0);
    last_gnt = 1'b0;

    // Randomized jobs against the reference model
    set_rom(2);
    for (int n = 0; n < 40; n++) begin
      vld = 2'($urandom_range(1, 3));
      b0  = 8'($urandom);
      b1  = 8'($urandom);
      c0  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 256)) : 9'($urandom_range(0, 12));
      c1  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 256)) : 9'($urandom_range(0, 12));
      if (vld == 2'b11) g = ~last_gnt;
      else              g = vld[1];
      last_gnt = g;
      do_job($sformatf("rnd%0d", n), vld, b0, b1, c0, c1, g,
             g ? ref_sum(int'(b1), int'(c1)) : ref_sum(int'(b0), int'(c0)),
             int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rom_sum_scheduler.md
Name: rom_sum_scheduler

Overview:
- Controller and arbiter for the ROM-read/accumulate datapath. Two requesters submit sum jobs; each job is a base address and a record count.
- The block grants one job at a time (round-robin), sequences the shared ROM address port, and accumulates the returned words, allowing for the ROM read latency.
- It returns the modular sum, tagged with the requester id, over a valid/ready result port.
- It sits between the day-level control logic and the single rom_feeder_generic instance.

Parameters:
- ADDR_W, 8, ROM address width in bits.
- DATA_W, 32, ROM word width and accumulator width in bits.
- ROM_LAT, 1, cycles from rom_addr driven to rom_data valid. Legal range is 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester job valid; bit i belongs to requester i.
- req_base  in  2*ADDR_W  per-requester start address; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_count  in  2*(ADDR_W+1)  per-requester word count, 0..2^ADDR_W; requester i occupies slice [i*(ADDR_W+1) +: ADDR_W+1].
- req_ready  out  2  per-requester accept strobe.
- rom_addr  out  ADDR_W  address to the ROM.
- rom_data  in  DATA_W  ROM read data.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_sum  out  DATA_W  accumulated sum.
- res_id  out  1  requester id of the result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous): state=IDLE, rom_addr=0, res_valid=0, res_sum=0, res_id=0, busy=0. The round-robin pointer is reset to 1, so requester 0 wins the first tie.
- req_ready is combinational. It is asserted only in IDLE, only for the granted requester, and only while that requester's req_valid=1. A job is accepted on a clock edge where req_valid[i] && req_ready[i].
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last time wins.
  - The pointer updates only on acceptance.
- States:
  - IDLE:
    - On acceptance, latch base, count and id; clear the accumulator and the index.
    - If count==0, go to DONE with sum 0. Otherwise go to ISSUE.
  - ISSUE:
    - Drive rom_addr = base+idx, truncated to ADDR_W bits; address wraps modulo 2^ADDR_W.
    - idx increments every cycle.
    - After the cycle in which idx==count-1 is issued, go to DRAIN.
  - DRAIN:
    - Wait ROM_LAT cycles. rom_addr holds its last value.
  - DONE:
    - res_valid=1, with res_sum and res_id stable.
    - On res_valid && res_ready, go to IDLE and deassert res_valid on the next cycle.
- Accumulation:
  - A ROM_LAT-deep valid shift register tracks issued addresses.
  - When the delayed valid is high, acc <= acc + rom_data, truncated to DATA_W bits; overflow wraps silently.
  - Exactly count words are summed per job.
- Latency: a job accepted at edge T gives res_valid=1 in cycle T+count+ROM_LAT+1. With count=0, res_valid=1 at T+1.
- Back-to-back jobs: new jobs are accepted only in IDLE, so there is at least one IDLE cycle between jobs. req_ready stays 0 while res_valid is pending.
- Requests that drop req_valid before being accepted are not remembered.
- Reset asserted mid-job aborts the job: the in-flight sum is discarded and no result is produced.
- rom_addr only changes in ISSUE and on acceptance.

Test Plan:
- ROM[i]=i, ROM_LAT=1. Requester 0 job (base=0, count=200) -> res_sum=19900, res_id=0, and res_valid rises exactly 202 cycles after acceptance.
- Both requesters valid in the same cycle from reset. Job 0 is (10,3) and job 1 is (20,2) on ROM[i]=i -> requester 0 is served first with sum 33; requester 1 is served next with sum 41. A third tie after that grants requester 0.
- Wrap-around: base=254, count=4, ROM[i]=i -> addresses 254,255,0,1 are issued, sum=510.
- count=0 -> res_valid one cycle after acceptance with sum 0 and no rom_addr change. count=256 with all words 0xFFFFFFFF -> sum=0xFFFFFF00.
- Hold res_ready=0 for 10 cycles in DONE -> res_valid, res_sum and res_id stay stable and req_ready=00. Raise res_ready -> IDLE on the next cycle.
- Assert rst_n=0 during ISSUE, mid-job -> outputs immediately return to their reset values. Release reset and submit a new job (0,2) -> correct sum of 1 with no residue from the aborted job.
